// File: rtl/pcie_read_scheduler_pkg.sv
// Shared constants, FSM state type and helpers
// for the PCIe DMA read-request scheduler.
package pcie_read_scheduler_pkg;

  localparam int REQ_BYTES     = 512;
  localparam int PAGE_BYTES    = 4096;
  localparam int REQS_PER_PAGE = 8;
  localparam int TAG_WIDTH     = 8;
  localparam int CHUNK_W       = $clog2(REQS_PER_PAGE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_WAIT
  } state_t;

  function automatic logic [5:0] popcount32(
    input logic [31:0] v
  );
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pcie_read_scheduler_tag_pool.sv
// Read-tag pool: free bitmap, lowest-free pick,
// free validation and registered in-use count.
module pcie_read_scheduler_tag_pool
  import pcie_read_scheduler_pkg::*;
#(
  parameter int                   NTAGS    = 8,
  parameter logic [TAG_WIDTH-1:0] TAG_BASE = 8'h00,
  localparam int IW = (NTAGS > 1) ? $clog2(NTAGS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc,
  input  logic                 free_valid,
  input  logic [TAG_WIDTH-1:0] free_tag,
  output logic                 any_free,
  output logic [IW-1:0]        alloc_idx,
  output logic                 free_err,
  output logic [5:0]           outstanding
);

  logic [NTAGS-1:0]     free_map;
  logic [NTAGS-1:0]     alloc_oh;
  logic [NTAGS-1:0]     free_oh;
  logic [NTAGS-1:0]     next_map;
  logic [TAG_WIDTH-1:0] off;

  assign off      = free_tag - TAG_BASE;
  assign any_free = |free_map;

  always_comb begin
    alloc_idx = '0;
    alloc_oh  = '0;
    free_oh   = '0;
    for (int i = NTAGS - 1; i >= 0; i--)
      if (free_map[i]) alloc_idx = IW'(i);
    for (int i = 0; i < NTAGS; i++) begin
      alloc_oh[i] = alloc && any_free &&
                    alloc_idx == IW'(i);
      // only a tag that is currently in use can be freed
      free_oh[i]  = free_valid &&
                    off == TAG_WIDTH'(i) &&
                    !free_map[i];
    end
  end

  assign free_err = free_valid && !(|free_oh);
  assign next_map = (free_map & ~alloc_oh) | free_oh;

  always_ff @(posedge clock) begin
    if (reset) begin
      free_map    <= '1;
      outstanding <= '0;
    end else begin
      free_map    <= next_map;
      outstanding <= 6'(NTAGS) -
                     popcount32(32'(next_map));
    end
  end

endmodule

// File: rtl/pcie_read_scheduler.sv
// Splits 4 KiB host pages into 512-byte read
// requests, gated by free tags and FIFO credits.
module pcie_read_scheduler
  import pcie_read_scheduler_pkg::*;
#(
  parameter int                   NTAGS    = 8,
  parameter logic [TAG_WIDTH-1:0] TAG_BASE = 8'h00,
  parameter int                   CREDITS  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 page_valid,
  input  logic [63:0]          page_addr,
  output logic                 page_ready,
  output logic                 read_request_valid,
  output logic [63:0]          read_request_address,
  output logic [TAG_WIDTH-1:0] read_request_tag,
  input  logic                 read_request_ready,
  input  logic                 tag_done_valid,
  input  logic [TAG_WIDTH-1:0] tag_done,
  input  logic                 credit_release,
  output logic [5:0]           outstanding,
  output logic                 busy,
  output logic                 error
);

  localparam int IW = (NTAGS > 1) ? $clog2(NTAGS) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [63:0] PAGE_MASK =
    ~64'(PAGE_BYTES - 1);

  state_t             state, state_nx;
  logic [63:0]        page;
  logic [CHUNK_W-1:0] chunk;
  logic [CW-1:0]      credits;
  logic               valid_reg;
  logic               any_free;
  logic [IW-1:0]      alloc_idx;
  logic               alloc;
  logic               free_err;
  logic               credit_ovf;
  logic               accept;
  logic               last;

  assign accept = state == S_IDLE &&
                  page_valid && enable;
  assign alloc  = state == S_ARB && enable &&
                  any_free && credits != '0;
  assign last   = chunk == CHUNK_W'(REQS_PER_PAGE - 1);

  // TX re-samples valid on its ready cycle, so mask it
  assign read_request_valid =
    valid_reg & ~read_request_ready;

  assign busy = state != S_IDLE || outstanding != '0;

  assign credit_ovf = credit_release && !alloc &&
                      credits == CW'(CREDITS);

  pcie_read_scheduler_tag_pool #(
    .NTAGS    (NTAGS),
    .TAG_BASE (TAG_BASE)
  ) u_pool (
    .clock       (clock),
    .reset       (reset),
    .alloc       (alloc),
    .free_valid  (tag_done_valid),
    .free_tag    (tag_done),
    .any_free    (any_free),
    .alloc_idx   (alloc_idx),
    .free_err    (free_err),
    .outstanding (outstanding)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_ARB;
      S_ARB:  if (alloc) state_nx = S_WAIT;
      S_WAIT:
        if (read_request_ready)
          state_nx = last ? S_IDLE : S_ARB;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      page                 <= '0;
      chunk                <= '0;
      credits              <= CW'(CREDITS);
      valid_reg            <= 1'b0;
      read_request_address <= '0;
      read_request_tag     <= '0;
      page_ready           <= 1'b0;
      error                <= 1'b0;
    end else begin
      page_ready <= accept;
      if (accept) begin
        page  <= page_addr & PAGE_MASK;
        chunk <= '0;
      end
      if (alloc) begin
        valid_reg            <= 1'b1;
        read_request_address <= page +
          (64'(chunk) << $clog2(REQ_BYTES));
        read_request_tag     <= TAG_BASE +
          TAG_WIDTH'(alloc_idx);
      end
      if (state == S_WAIT && read_request_ready) begin
        valid_reg <= 1'b0;
        if (!last) chunk <= chunk + 1'b1;
      end
      if (alloc && !credit_release)
        credits <= credits - 1'b1;
      else if (credit_release && !alloc && !credit_ovf)
        credits <= credits + 1'b1;
      error <= error | free_err | credit_ovf;
    end
  end

endmodule

// File: tb/tb_pcie_read_scheduler.sv
// Directed bench: three scheduler instances
// (default, 4 tags, 2 credits) with a TX model.
module tb_pcie_read_scheduler;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [2:0]       en, pv, rr, tdv, cr;
  logic [2:0][63:0] pa;
  logic [2:0][7:0]  td;
  logic [2:0]       pr, rv, bz, er;
  logic [2:0][63:0] ra;
  logic [2:0][7:0]  rt;
  logic [2:0][5:0]  os;

  int checks = 0;
  int errors = 0;
  int prcnt  = 0;

  localparam logic [63:0] PG_A = 64'h0000_0001_2345_6000;
  localparam logic [63:0] PG_B = 64'h0000_00AB_CDEF_1000;

  always #5 clk = ~clk;

  always @(negedge clk) if (pr[0]) prcnt++;

  pcie_read_scheduler u0 (
    .clock(clk), .reset(rst), .enable(en[0]),
    .page_valid(pv[0]), .page_addr(pa[0]),
    .page_ready(pr[0]),
    .read_request_valid(rv[0]),
    .read_request_address(ra[0]),
    .read_request_tag(rt[0]),
    .read_request_ready(rr[0]),
    .tag_done_valid(tdv[0]), .tag_done(td[0]),
    .credit_release(cr[0]), .outstanding(os[0]),
    .busy(bz[0]), .error(er[0])
  );

  pcie_read_scheduler #(.NTAGS(4)) u1 (
    .clock(clk), .reset(rst), .enable(en[1]),
    .page_valid(pv[1]), .page_addr(pa[1]),
    .page_ready(pr[1]),
    .read_request_valid(rv[1]),
    .read_request_address(ra[1]),
    .read_request_tag(rt[1]),
    .read_request_ready(rr[1]),
    .tag_done_valid(tdv[1]), .tag_done(td[1]),
    .credit_release(cr[1]), .outstanding(os[1]),
    .busy(bz[1]), .error(er[1])
  );

  pcie_read_scheduler #(.CREDITS(2)) u2 (
    .clock(clk), .reset(rst), .enable(en[2]),
    .page_valid(pv[2]), .page_addr(pa[2]),
    .page_ready(pr[2]),
    .read_request_valid(rv[2]),
    .read_request_address(ra[2]),
    .read_request_tag(rt[2]),
    .read_request_ready(rr[2]),
    .tag_done_valid(tdv[2]), .tag_done(td[2]),
    .credit_release(cr[2]), .outstanding(os[2]),
    .busy(bz[2]), .error(er[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = '1;
    pv  = '0;
    rr  = '0;
    tdv = '0;
    cr  = '0;
    pa  = '0;
    td  = '0;
    tick();
    tick();
    rst   = 1'b0;
    prcnt = 0;
  endtask

  task automatic offer(input int k, input logic [63:0] a);
    int n;
    n     = 0;
    pv[k] = 1'b1;
    pa[k] = a;
    tick();
    while (pr[k] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    pv[k] = 1'b0;
    checks++;
    if (pr[k] !== 1'b1) begin
      errors++;
      $display("FAIL page_ready k=%0d got %b want 1",
               k, pr[k]);
    end
  endtask

  task automatic serve(input int k,
                       input logic [63:0] ea,
                       input logic [7:0] et);
    int n;
    n = 0;
    while (rv[k] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (rv[k] !== 1'b1) begin
      errors++;
      $display("FAIL req_timeout k=%0d got %b want 1",
               k, rv[k]);
      return;
    end
    checks++;
    if (ra[k] !== ea || rt[k] !== et) begin
      errors++;
      $display("FAIL req_fields k=%0d got %h/%h want %h/%h",
               k, ra[k], rt[k], ea, et);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rv[k] !== 1'b1 || ra[k] !== ea ||
          rt[k] !== et) begin
        errors++;
        $display("FAIL req_hold k=%0d got %b %h/%h want 1 %h/%h",
                 k, rv[k], ra[k], rt[k], ea, et);
      end
    end
    rr[k] = 1'b1;
    #1;
    checks++;
    if (rv[k] !== 1'b0) begin
      errors++;
      $display("FAIL ready_gate k=%0d got %b want 0",
               k, rv[k]);
    end
    tick();
    rr[k] = 1'b0;
    #1;
    checks++;
    if (rv[k] !== 1'b0) begin
      errors++;
      $display("FAIL dup_req k=%0d got %b want 0",
               k, rv[k]);
    end
  endtask

  task automatic expect_quiet(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      checks++;
      if (rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL stall k=%0d cyc=%0d got %b want 0",
                 k, i, rv[k]);
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({pr[k], rv[k], bz[k], er[k]} !== 4'b0 ||
          ra[k] !== 64'h0 || rt[k] !== 8'h0 ||
          os[k] !== 6'h0) begin
        errors++;
        $display("FAIL reset k=%0d got %b%b%b%b %h %h %0d want zeros",
                 k, pr[k], rv[k], bz[k], er[k],
                 ra[k], rt[k], os[k]);
      end
    end
  endtask

  task automatic test_full_page();
    apply_reset();
    offer(0, PG_A | 64'h123);
    for (int i = 0; i < 8; i++)
      serve(0, PG_A + 64'(i * 512), 8'(i));
    tick();
    checks++;
    if (os[0] !== 6'd8 || bz[0] !== 1'b1 ||
        prcnt !== 1) begin
      errors++;
      $display("FAIL page_end got os=%0d busy=%b pr=%0d want 8 1 1",
               os[0], bz[0], prcnt);
    end
    for (int i = 0; i < 8; i++) begin
      tdv[0] = 1'b1;
      td[0]  = 8'(i);
      tick();
    end
    tdv[0] = 1'b0;
    tick();
    checks++;
    if (os[0] !== 6'd0 || bz[0] !== 1'b0 ||
        er[0] !== 1'b0) begin
      errors++;
      $display("FAIL free_all got os=%0d busy=%b err=%b want 0 0 0",
               os[0], bz[0], er[0]);
    end
  endtask

  task automatic test_tag_limit();
    apply_reset();
    offer(1, PG_A);
    for (int i = 0; i < 4; i++)
      serve(1, PG_A + 64'(i * 512), 8'(i));
    expect_quiet(1, 8);
    checks++;
    if (os[1] !== 6'd4) begin
      errors++;
      $display("FAIL tag_limit_os got %0d want 4", os[1]);
    end
    tdv[1] = 1'b1;
    td[1]  = 8'd2;
    tick();
    tdv[1] = 1'b0;
    serve(1, PG_A + 64'h800, 8'd2);
    expect_quiet(1, 4);
    checks++;
    if (os[1] !== 6'd4 || er[1] !== 1'b0) begin
      errors++;
      $display("FAIL tag_reuse got os=%0d err=%b want 4 0",
               os[1], er[1]);
    end
  endtask

  task automatic test_credits();
    apply_reset();
    offer(2, PG_A);
    serve(2, PG_A, 8'd0);
    serve(2, PG_A + 64'h200, 8'd1);
    expect_quiet(2, 8);
    cr[2] = 1'b1;
    tick();
    cr[2] = 1'b0;
    serve(2, PG_A + 64'h400, 8'd2);
    expect_quiet(2, 8);
    checks++;
    if (os[2] !== 6'd3 || er[2] !== 1'b0) begin
      errors++;
      $display("FAIL credit_stall got os=%0d err=%b want 3 0",
               os[2], er[2]);
    end
  endtask

  task automatic test_errors();
    apply_reset();
    tdv[0] = 1'b1;
    td[0]  = 8'h05;
    tick();
    tdv[0] = 1'b0;
    checks++;
    if (er[0] !== 1'b1 || os[0] !== 6'd0) begin
      errors++;
      $display("FAIL double_free got err=%b os=%0d want 1 0",
               er[0], os[0]);
    end
    apply_reset();
    checks++;
    if (er[0] !== 1'b0) begin
      errors++;
      $display("FAIL err_clear got %b want 0", er[0]);
    end
    cr[0] = 1'b1;
    tick();
    cr[0] = 1'b0;
    checks++;
    if (er[0] !== 1'b1 || u0.credits !== 4'd8) begin
      errors++;
      $display("FAIL credit_ovf got err=%b cr=%0d want 1 8",
               er[0], u0.credits);
    end
    apply_reset();
    tdv[0] = 1'b1;
    td[0]  = 8'h08;
    tick();
    tdv[0] = 1'b0;
    checks++;
    if (er[0] !== 1'b1 || os[0] !== 6'd0) begin
      errors++;
      $display("FAIL tag_range got err=%b os=%0d want 1 0",
               er[0], os[0]);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    en[0] = 1'b0;
    pv[0] = 1'b1;
    pa[0] = PG_B;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pr[0] !== 1'b0) begin
        errors++;
        $display("FAIL en_idle got %b want 0", pr[0]);
      end
    end
    en[0] = 1'b1;
    tick();
    pv[0] = 1'b0;
    en[0] = 1'b0;
    checks++;
    if (pr[0] !== 1'b1) begin
      errors++;
      $display("FAIL en_accept got %b want 1", pr[0]);
    end
    expect_quiet(0, 5);
    en[0] = 1'b1;
    serve(0, PG_B, 8'd0);
  endtask

  task automatic test_mid_reset();
    int n;
    apply_reset();
    offer(0, PG_A);
    for (int i = 0; i < 3; i++)
      serve(0, PG_A + 64'(i * 512), 8'(i));
    n = 0;
    while (rv[0] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rv[0] !== 1'b1 || ra[0] !== PG_A + 64'h600) begin
      errors++;
      $display("FAIL chunk3 got %b %h want 1 %h",
               rv[0], ra[0], PG_A + 64'h600);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (rv[0] !== 1'b0 || os[0] !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset got v=%b os=%0d want 0 0",
               rv[0], os[0]);
    end
    rst = 1'b0;
    offer(0, PG_B);
    serve(0, PG_B, 8'd0);
    serve(0, PG_B + 64'h200, 8'd1);
  endtask

  initial begin
    test_reset();
    test_full_page();
    test_tag_limit();
    test_credits();
    test_errors();
    test_enable();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
